// File: rtl/bin_to_bcd_serial.sv
// Serial double-dabble binary-to-BCD converter.
// One input bit is consumed per clock; the result is published as four packed
// BCD digits, plus an overflow flag when the value needs a fifth digit.
module bin_to_bcd_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk_pi,
  input  logic             rst_pi,
  input  logic             start_pi,
  input  logic [WIDTH-1:0] bin_pi,
  output logic             busy_po,
  output logic             done_po,
  output logic [15:0]      bcd_po,
  output logic             ovf_po
);

  localparam int DIGITS = 5;
  localparam int BCD_W  = DIGITS * 4;
  localparam int SR_W   = BCD_W + WIDTH;
  localparam int CW     = $clog2(WIDTH + 1);
  // Below 14 bits the largest input is 8191, so a fifth digit can never appear.
  localparam bit OVF_POSSIBLE = (WIDTH >= 14);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [SR_W-1:0] shift_reg;
  logic [SR_W-1:0] adj;
  logic [CW-1:0]   count_reg;
  logic            busy_reg, done_reg, ovf_reg;
  logic [15:0]     bcd_reg;

  // Output-process decodes
  logic            load, shift_en, publish;
  logic            busy_next;

  // Per-digit "add 3 when >= 5" correction ahead of each shift; binary part passes through.
  assign adj[WIDTH-1:0] = shift_reg[WIDTH-1:0];
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      always_comb begin
        if (shift_reg[WIDTH + gi*4 +: 4] >= 4'd5)
          adj[WIDTH + gi*4 +: 4] = shift_reg[WIDTH + gi*4 +: 4] + 4'd3;
        else
          adj[WIDTH + gi*4 +: 4] = shift_reg[WIDTH + gi*4 +: 4];
      end
    end
  endgenerate

  // State register.
  always_ff @(posedge clk_pi) begin
    if (rst_pi) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: SHIFT leaves once the last bit has gone through.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_pi) state_next = SHIFT;
      SHIFT:   if (count_reg == CW'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output/control decode from the current state.
  always_comb begin
    load      = (state_reg == IDLE) && start_pi;
    shift_en  = (state_reg == SHIFT);
    publish   = (state_reg == DONE);
    busy_next = (state_reg == SHIFT);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      shift_reg <= '0;
      count_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      bcd_reg   <= 16'h0000;
      ovf_reg   <= 1'b0;
    end else begin
      busy_reg <= busy_next;
      done_reg <= publish;
      if (load) begin
        shift_reg <= {{BCD_W{1'b0}}, bin_pi};
        count_reg <= CW'(WIDTH);
      end else if (shift_en) begin
        shift_reg <= {adj[SR_W-2:0], 1'b0};
        count_reg <= count_reg - CW'(1);
      end
      if (publish) begin
        bcd_reg <= shift_reg[WIDTH +: 16];
        ovf_reg <= OVF_POSSIBLE && (shift_reg[WIDTH + 16 +: 4] != 4'd0);
      end
    end
  end

  assign busy_po = busy_reg;
  assign done_po = done_reg;
  assign bcd_po  = bcd_reg;
  assign ovf_po  = ovf_reg;

endmodule
